// File: rtl/pause_pkg.sv
// rtl/pause_pkg.sv - shared state encoding and option bit positions for the pause controller
package pause_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    PAUSED = 2'd2,
    STEP   = 2'd3
  } pause_state_e;

  localparam int OPT_OSD = 0;
  localparam int OPT_DIM = 1;

endpackage

// File: rtl/pause_dim_fader.sv
// rtl/pause_dim_fader.sv - burn-in dimmer: waits DIM_SECS of pause, then steps dim level every FADE_FRAMES vblanks
module pause_dim_fader #(
  parameter int unsigned TICK_CYCLES = 12_000_000,
  parameter int unsigned DIM_SECS    = 10,
  parameter int unsigned DIM_SHIFT   = 3,
  parameter int unsigned FADE_FRAMES = 8
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             vb_rise,
  output logic [$clog2(DIM_SHIFT+1)-1:0]   dim_level
);

  localparam int unsigned PW = $clog2(TICK_CYCLES + 1);
  localparam int unsigned SW = $clog2(DIM_SECS + 1);
  localparam int unsigned FW = $clog2(FADE_FRAMES + 1);
  localparam int unsigned LW = $clog2(DIM_SHIFT + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SEC_MAX    = SW'(DIM_SECS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FADE_FRAMES - 1);
  localparam logic [LW-1:0] LVL_MAX    = LW'(DIM_SHIFT);

  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [LW-1:0] lvl_q, lvl_d;

  always_comb begin
    pre_d   = pre_q;
    sec_d   = sec_q;
    frame_d = frame_q;
    lvl_d   = lvl_q;
    if (!enable) begin
      pre_d   = '0;
      sec_d   = '0;
      frame_d = '0;
      lvl_d   = '0;
    end else if (sec_q != SEC_MAX) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        sec_d = sec_q + SW'(1);
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else if (vb_rise && (lvl_q != LVL_MAX)) begin
      // Fading only starts once the idle-seconds counter has saturated
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        lvl_d   = lvl_q + LW'(1);
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pre_q   <= '0;
      sec_q   <= '0;
      frame_q <= '0;
      lvl_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      frame_q <= frame_d;
      lvl_q   <= lvl_d;
    end
  end

  // Leaving the dimmed state drops brightness back to full in the same cycle
  assign dim_level = enable ? lvl_q : '0;

endmodule

// File: rtl/pause_ctrl.sv
// rtl/pause_ctrl.sv - pause controller: request merge, vblank-aligned pause FSM, frame step, dimmed RGB output
module pause_ctrl
  import pause_pkg::*;
#(
  parameter int unsigned RW          = 8,
  parameter int unsigned GW          = 8,
  parameter int unsigned BW          = 8,
  parameter int unsigned CLKSPD      = 12,
  parameter int unsigned NREQ        = 2,
  parameter int unsigned SYNC_VBLANK = 1,
  parameter int unsigned DIM_SECS    = 10,
  parameter int unsigned DIM_SHIFT   = 3,
  parameter int unsigned FADE_FRAMES = 8,
  parameter int unsigned TICK_CYCLES = CLKSPD * 1_000_000
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            user_button,
  input  logic                            step_button,
  input  logic [NREQ-1:0]                 pause_request,
  input  logic [1:0]                      options,
  input  logic                            OSD_STATUS,
  input  logic                            vblank,
  input  logic [RW-1:0]                   r,
  input  logic [GW-1:0]                   g,
  input  logic [BW-1:0]                   b,
  output logic                            pause_cpu,
  output logic                            dim_video,
  output logic [$clog2(DIM_SHIFT+1)-1:0]  dim_level,
  output logic [RW+GW+BW-1:0]             rgb_out
);

  logic btn_q, step_q, vb_q, toggle_q, toggle_d, pause_q, pause_d;
  logic btn_rise, step_rise, vb_rise, want, dim_en;
  pause_state_e state_q, state_d;
  logic [RW+GW+BW-1:0] rgb_q, rgb_d;

  always_comb begin
    btn_rise  = user_button & ~btn_q;
    step_rise = step_button & ~step_q;
    vb_rise   = vblank & ~vb_q;
    toggle_d  = toggle_q ^ btn_rise;
    want      = toggle_q | (|pause_request) | (OSD_STATUS & options[OPT_OSD]);

    state_d = state_q;
    case (state_q)
      RUN:     if (want) state_d = (SYNC_VBLANK != 0) ? PEND : PAUSED;
      PEND:    if (!want) state_d = RUN; else if (vb_rise) state_d = PAUSED;
      PAUSED:  if (!want) state_d = RUN; else if (step_rise) state_d = STEP;
      STEP:    if (!want) state_d = RUN; else if (vb_rise) state_d = PAUSED;
      default: state_d = RUN;
    endcase
    pause_d = (state_d == PAUSED);

    dim_en = (state_q == PAUSED) && options[OPT_DIM];
    rgb_d  = {r >> dim_level, g >> dim_level, b >> dim_level};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_q    <= 1'b0;
      step_q   <= 1'b0;
      vb_q     <= 1'b0;
      toggle_q <= 1'b0;
      state_q  <= RUN;
      pause_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      btn_q    <= user_button;
      step_q   <= step_button;
      vb_q     <= vblank;
      toggle_q <= toggle_d;
      state_q  <= state_d;
      pause_q  <= pause_d;
      rgb_q    <= rgb_d;
    end
  end

  pause_dim_fader #(
    .TICK_CYCLES (TICK_CYCLES),
    .DIM_SECS    (DIM_SECS),
    .DIM_SHIFT   (DIM_SHIFT),
    .FADE_FRAMES (FADE_FRAMES)
  ) u_fader (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .enable    (dim_en),
    .vb_rise   (vb_rise),
    .dim_level (dim_level)
  );

  assign pause_cpu = pause_q;
  assign dim_video = (dim_level != '0);
  assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_pause_ctrl.sv
// tb/tb_pause_ctrl.sv - self-checking bench for pause_ctrl, vblank-synced and immediate-entry instances
module tb_pause_ctrl;

  localparam int P     = 64;
  localparam int FADE  = 2;
  localparam int DSH   = 3;

  logic clk = 1'b0;
  logic reset, user_button, step_button, osd, vblank;
  logic [1:0] pause_request, options;
  logic [7:0] r, g, b;
  logic pause_cpu, dim_video, s0_pause_cpu, s0_dim_video;
  logic [1:0] dim_level, s0_dim_level;
  logic [23:0] rgb_out, s0_rgb_out;

  int chk = 0;
  int pass = 0;

  always #5 clk = ~clk;

  pause_ctrl #(.RW(8), .GW(8), .BW(8), .CLKSPD(1), .NREQ(2), .SYNC_VBLANK(1), .DIM_SECS(1),
               .DIM_SHIFT(DSH), .FADE_FRAMES(FADE), .TICK_CYCLES(P)) dut (
    .clk_sys(clk), .reset(reset), .user_button(user_button), .step_button(step_button),
    .pause_request(pause_request), .options(options), .OSD_STATUS(osd), .vblank(vblank),
    .r(r), .g(g), .b(b), .pause_cpu(pause_cpu), .dim_video(dim_video),
    .dim_level(dim_level), .rgb_out(rgb_out));

  pause_ctrl #(.RW(8), .GW(8), .BW(8), .CLKSPD(1), .NREQ(2), .SYNC_VBLANK(0), .DIM_SECS(1),
               .DIM_SHIFT(DSH), .FADE_FRAMES(FADE), .TICK_CYCLES(P)) dut_nosync (
    .clk_sys(clk), .reset(reset), .user_button(user_button), .step_button(step_button),
    .pause_request(pause_request), .options(options), .OSD_STATUS(osd), .vblank(vblank),
    .r(r), .g(g), .b(b), .pause_cpu(s0_pause_cpu), .dim_video(s0_dim_video),
    .dim_level(s0_dim_level), .rgb_out(s0_rgb_out));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; user_button = 1'b0; step_button = 1'b0; pause_request = 2'b00;
    options = 2'b00; osd = 1'b0; vblank = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic press_user();
    user_button = 1'b1; cyc();
    user_button = 1'b0; cyc();
  endtask

  task automatic vb_pulse();
    vblank = 1'b1; cyc();
    vblank = 1'b0; cyc();
  endtask

  task automatic test_reset();
    r = 8'hA5; g = 8'h5A; b = 8'hFF;
    do_reset();
    chk++; if (pause_cpu !== 1'b0) $display("FAIL reset_pause: got %0b want 0", pause_cpu); else pass++;
    chk++; if (dim_level !== 2'd0) $display("FAIL reset_dim_level: got %0d want 0", dim_level); else pass++;
    chk++; if (dim_video !== 1'b0) $display("FAIL reset_dim_video: got %0b want 0", dim_video); else pass++;
    chk++; if (rgb_out !== 24'h0) $display("FAIL reset_rgb: got %06h want 000000", rgb_out); else pass++;
    chk++; if (s0_pause_cpu !== 1'b0) $display("FAIL reset_nosync_pause: got %0b want 0", s0_pause_cpu); else pass++;
  endtask

  task automatic test_no_sync();
    do_reset();
    repeat ($urandom_range(1, 10)) cyc();
    user_button = 1'b1; cyc();
    chk++; if (s0_pause_cpu !== 1'b0) $display("FAIL nosync_lat1: got %0b want 0", s0_pause_cpu); else pass++;
    user_button = 1'b0; cyc();
    chk++; if (s0_pause_cpu !== 1'b1) $display("FAIL nosync_lat2: got %0b want 1", s0_pause_cpu); else pass++;
  endtask

  task automatic test_pause_entry();
    int bad;
    do_reset();
    repeat ($urandom_range(1, 20)) cyc();
    press_user();
    chk++; if (pause_cpu !== 1'b0) $display("FAIL entry_pend: got %0b want 0", pause_cpu); else pass++;
    bad = 0;
    repeat ($urandom_range(1, 30)) begin
      cyc();
      if (pause_cpu !== 1'b0) bad++;
    end
    chk++; if (bad != 0) $display("FAIL entry_pend_hold: got %0d early cycles want 0", bad); else pass++;
    vblank = 1'b1; cyc();
    chk++; if (pause_cpu !== 1'b1) $display("FAIL entry_vblank: got %0b want 1", pause_cpu); else pass++;
    vblank = 1'b0; cyc();
    press_user();
    chk++; if (pause_cpu !== 1'b0) $display("FAIL entry_unpause: got %0b want 0", pause_cpu); else pass++;
    chk++; if (s0_pause_cpu !== 1'b0) $display("FAIL entry_nosync_unpause: got %0b want 0", s0_pause_cpu); else pass++;
  endtask

  task automatic test_step();
    int bad, n, m;
    press_user();
    vb_pulse();
    chk++; if (pause_cpu !== 1'b1) $display("FAIL step_pre_paused: got %0b want 1", pause_cpu); else pass++;
    repeat ($urandom_range(1, 8)) cyc();
    step_button = 1'b1; cyc();
    step_button = 1'b0;
    chk++; if (pause_cpu !== 1'b0) $display("FAIL step_start: got %0b want 0", pause_cpu); else pass++;
    n = $urandom_range(4, 20);
    m = $urandom_range(1, n - 2);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step_button = (i == m);
      cyc();
      if (pause_cpu !== 1'b0) bad++;
    end
    step_button = 1'b0;
    chk++; if (bad != 0) $display("FAIL step_frame_run: got %0d paused cycles want 0", bad); else pass++;
    vblank = 1'b1; cyc();
    chk++; if (pause_cpu !== 1'b1) $display("FAIL step_end: got %0b want 1", pause_cpu); else pass++;
    vblank = 1'b0;
    bad = 0;
    repeat (6) begin
      cyc();
      if (pause_cpu !== 1'b1) bad++;
    end
    chk++; if (bad != 0) $display("FAIL step_extra_ignored: got %0d running cycles want 0", bad); else pass++;
  endtask

  task automatic test_dim();
    int bad, i, exp_lvl;
    logic [23:0] exp_rgb;
    r = 8'hF0; g = 8'($urandom); b = 8'($urandom);
    options = 2'b10;
    bad = 0;
    i = 0;
    while (i < P) begin
      if (($urandom_range(0, 7) == 0) && (i + 2 <= P)) begin
        vblank = 1'b1; cyc(); if (dim_level !== 2'd0) bad++;
        vblank = 1'b0; cyc(); if (dim_level !== 2'd0) bad++;
        i += 2;
      end else begin
        cyc(); if (dim_level !== 2'd0) bad++;
        i++;
      end
    end
    chk++; if (bad != 0) $display("FAIL dim_wait: got %0d dimmed cycles want 0", bad); else pass++;
    for (int j = 1; j <= 8; j++) begin
      repeat ($urandom_range(0, 5)) cyc();
      vblank = 1'b1; cyc();
      exp_lvl = (j / FADE > DSH) ? DSH : j / FADE;
      chk++;
      if (dim_level !== 2'(exp_lvl) || dim_video !== (exp_lvl != 0))
        $display("FAIL dim_step%0d: got lvl %0d vid %0b want lvl %0d", j, dim_level, dim_video, exp_lvl);
      else pass++;
      vblank = 1'b0; cyc();
    end
    cyc();
    chk++; if (rgb_out[23:16] !== 8'h1E) $display("FAIL dim_red: got %02h want 1E", rgb_out[23:16]); else pass++;
    repeat (3) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      cyc();
      exp_rgb = {r >> DSH, g >> DSH, b >> DSH};
      chk++; if (rgb_out !== exp_rgb) $display("FAIL dim_rgb: got %06h want %06h", rgb_out, exp_rgb); else pass++;
    end
    r = 8'hF0;
    press_user();
    chk++; if (dim_level !== 2'd0) $display("FAIL undim_level: got %0d want 0", dim_level); else pass++;
    cyc();
    exp_rgb = {r, g, b};
    chk++; if (rgb_out !== exp_rgb) $display("FAIL undim_rgb: got %06h want %06h", rgb_out, exp_rgb); else pass++;
  endtask

  task automatic test_requests();
    int k;
    do_reset();
    k = $urandom_range(0, 1);
    pause_request = 2'b01 << k;
    cyc();
    chk++; if (pause_cpu !== 1'b0) $display("FAIL req_pend: got %0b want 0", pause_cpu); else pass++;
    chk++; if (s0_pause_cpu !== 1'b1) $display("FAIL req_nosync: got %0b want 1", s0_pause_cpu); else pass++;
    vblank = 1'b1; cyc();
    chk++; if (pause_cpu !== 1'b1) $display("FAIL req_paused: got %0b want 1", pause_cpu); else pass++;
    vblank = 1'b0; cyc();
    pause_request = 2'b00; cyc();
    chk++; if (pause_cpu !== 1'b0) $display("FAIL req_release: got %0b want 0", pause_cpu); else pass++;
    osd = 1'b1; options = 2'b00;
    repeat (3) vb_pulse();
    chk++; if (pause_cpu !== 1'b0 || s0_pause_cpu !== 1'b0)
      $display("FAIL osd_masked: got %0b/%0b want 0/0", pause_cpu, s0_pause_cpu); else pass++;
    options = 2'b01; cyc();
    vb_pulse();
    chk++; if (pause_cpu !== 1'b1) $display("FAIL osd_pause: got %0b want 1", pause_cpu); else pass++;
    osd = 1'b0; cyc();
    chk++; if (pause_cpu !== 1'b0) $display("FAIL osd_release: got %0b want 0", pause_cpu); else pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    options = 2'b10;
    r = 8'hFF; g = 8'hFF; b = 8'hFF;
    press_user();
    vb_pulse();
    repeat (P + 2) cyc();
    vb_pulse();
    vb_pulse();
    chk++; if (dim_level !== 2'd1) $display("FAIL rmid_pre_dim: got %0d want 1", dim_level); else pass++;
    reset = 1'b1; user_button = 1'b1; cyc();
    chk++; if (pause_cpu !== 1'b0) $display("FAIL rmid_pause: got %0b want 0", pause_cpu); else pass++;
    chk++; if (dim_level !== 2'd0) $display("FAIL rmid_dim: got %0d want 0", dim_level); else pass++;
    chk++; if (rgb_out !== 24'h0) $display("FAIL rmid_rgb: got %06h want 000000", rgb_out); else pass++;
    reset = 1'b0; user_button = 1'b0; cyc();
    vb_pulse();
    vb_pulse();
    chk++; if (pause_cpu !== 1'b0 || s0_pause_cpu !== 1'b0)
      $display("FAIL rmid_toggle: got %0b/%0b want 0/0", pause_cpu, s0_pause_cpu); else pass++;
    cyc();
    chk++; if (rgb_out !== 24'hFFFFFF) $display("FAIL rmid_bright: got %06h want FFFFFF", rgb_out); else pass++;
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_pause_entry();
    test_step();
    test_dim();
    test_requests();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
